// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor, DIFF = A - B, processed LSB first through a single
//   full-subtractor cell and a borrow flip-flop. This is the low-area
//   subtract/compare path for the ALU and mirrors the ripple full-adder
//   datapath in the opposite direction.
//
//   An accepted start captures the operands. WIDTH bit-cycles follow, then
//   done pulses for one cycle with diff/borrow_out valid. diff and borrow_out
//   hold their values until the last bit-edge of the next operation.
//
//   Optional build macro: SERSUB_FLAGS_EN adds the zero and overflow flag
//   ports. They update together with diff.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start
//   SHIFT | one operand bit per edge, busy=1
//   DONE  | result valid, done=1 for one cycle; start accepted here too
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only when not busy
//   a, b       minuend / subtrahend, captured at the accepting edge
//   busy       bit-cycles in progress
//   done       one-cycle pulse, result valid
//   diff       A - B modulo 2^WIDTH
//   borrow_out final borrow (unsigned A < B)
//   zero       diff == 0              (SERSUB_FLAGS_EN only)
//   overflow   signed overflow of A-B (SERSUB_FLAGS_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERSUB_FLAGS_EN
   ,
   output logic             zero,
   output logic             overflow
`endif
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic [WIDTH-1:0] res_nxt;
   logic             bor, bor_nxt;
   logic             a0, b0, d;
   logic [CNT_W-1:0] count;
   logic             last_bit;
   logic             accept;

`ifdef SERSUB_FLAGS_EN
   logic             a_msb, b_msb;
`endif

   // single full-subtractor cell
   assign a0      = a_sh[0];
   assign b0      = b_sh[0];
   assign d       = a0 ^ b0 ^ bor;
   assign bor_nxt = (~a0 & b0) | (~(a0 ^ b0) & bor);
   // result fills from the MSB end so the first (LSB) bit lands at bit 0
   // after WIDTH shifts
   assign res_nxt = {d, res_sh[WIDTH-1:1]};

   assign last_bit = (count == CNT_W'(WIDTH - 1));
   assign accept   = start && (state != SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         bor        <= 1'b0;
         count      <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SERSUB_FLAGS_EN
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
`endif
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         res_sh <= '0;
         bor    <= 1'b0;
         count  <= '0;
`ifdef SERSUB_FLAGS_EN
         // operand MSBs are shifted out of a_sh/b_sh, so keep them for the
         // overflow flag
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         res_sh <= res_nxt;
         bor    <= bor_nxt;
         count  <= count + 1'b1;
         if (last_bit) begin
            diff       <= res_nxt;
            borrow_out <= bor_nxt;
`ifdef SERSUB_FLAGS_EN
            zero       <= (res_nxt == '0);
            // d is the MSB of the final difference on the last bit-edge
            overflow   <= (a_msb != b_msb) && (d != a_msb);
`endif
         end
      end
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, multi-cycle subtractor computing DIFF = A − B, LSB first, with one full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion of the team's ripple full-adder datapath.
- It serves as the ALU's low-area subtract/compare path.
- Operands are captured on a start pulse; the result is presented with a one-cycle done pulse after WIDTH bit-cycles.

Parameters:
WIDTH, 8, operand and result width in bits (≥2).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
a  input  WIDTH  minuend, sampled at accepted start
b  input  WIDTH  subtrahend, sampled at accepted start
busy  output  1  high while bit-cycles are in progress
done  output  1  one-cycle pulse; diff/borrow_out valid
diff  output  WIDTH  A − B modulo 2^WIDTH
borrow_out  output  1  final borrow (1 iff unsigned A < B)
zero  output  1  diff == 0 (SERSUB_FLAGS_EN only)
overflow  output  1  signed overflow (SERSUB_FLAGS_EN only)

Behaviour:
- Reset is asynchronous on rst_n low and has priority over everything.
  - state=IDLE; busy, done, diff, borrow_out, zero, overflow = 0; internal shift registers, borrow FF and counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 → load a_sh←a, b_sh←b, borrow FF←0, count←0, state←SHIFT, busy←1, done←0.
  - start=0 → remain in IDLE.
- SHIFT, one bit per edge, using the LSBs of a_sh and b_sh (a0, b0):
  - d = a0 ^ b0 ^ bor
  - bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor)
  - d shifts into the result register from the MSB end; a_sh and b_sh shift right by one.
  - count increments by 1.
  - The edge on which count reaches WIDTH−1 processes the last bit. That edge (E_WIDTH) sets state←DONE, busy←0, done←1, diff←final result, borrow_out←bor_next.
- Latency: start accepted at E0 → done high for exactly the cycle following edge E_WIDTH, i.e. WIDTH+1 edges from request to result.
- DONE (one cycle):
  - done←0 at the next edge.
  - If start=1 at that edge, it is accepted exactly as in IDLE: new capture, done drops, busy rises.
  - Otherwise state←IDLE.
- diff and borrow_out hold their values until the last bit-edge of the next operation. They do not change during a subsequent busy period until the final update.
- start while busy=1 is ignored; operands are not re-sampled and the operation is unaffected.
- a and b may change freely after the accepting edge.
- Reset asserted mid-SHIFT aborts the operation. All outputs read 0, no done pulse is produced, and the first start after release begins a fresh operation.
- Arithmetic is modulo 2^WIDTH. borrow_out equals the unsigned comparison A < B.

Optional Feature:
Macro: SERSUB_FLAGS_EN.
- Defined:
  - zero and overflow ports exist.
  - Both update on the same edge as diff and hold with it.
  - zero = (diff == 0).
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the captured operand MSBs.
  - Both reset to 0.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8: a=0x05, b=0x03, start pulse → busy high for 8 cycles; done on the 9th edge after acceptance; diff=0x02, borrow_out=0, zero=0, overflow=0.
2. a=0x03, b=0x05 → diff=0xFE, borrow_out=1, overflow=0.
3. a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1. Then a=0x2A, b=0x2A → diff=0x00, zero=1, borrow_out=0.
4. start held high continuously with a=0x10, b=0x01:
   - Mid-operation, change a/b to 0xFF/0xFF.
   - Required: first result 0x0F; a new operation is accepted on the DONE-cycle edge; its result is 0x00, zero=1.
   - No operand change is seen during busy.
5. rst_n pulled low at the 4th bit-cycle of a=0x55, b=0x22 → outputs immediately 0, no done pulse. After release, start with a=0x55, b=0x22 → diff=0x33, borrow_out=0.
6. WIDTH=16 override: a=0x0000, b=0x0001 → diff=0xFFFF, borrow_out=1, done exactly 17 edges after start.
